// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle MIPS control FSM.
// State encodings, opcode/funct values, ALU control codes and mux encodings.
// Optional feature macro used by the FSM: MC_CTRL_BNE_EN (bne support).
package mc_ctrl_pkg;

    // FSM state encodings (4-bit, exposed on the debug state output)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    // R-type function fields
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: IR/datapath/memory-side signals of the control FSM.
// Handshake: mem_ready is sampled only while the FSM requests memory
// (FETCH, MEMRD, MEMWR); a request is held until mem_ready=1 in that cycle.
// master = the control FSM, slave = datapath/memory side.
interface mc_ctrl_fsm_if #(parameter int BEATS = 4);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [BEATS-1:0] ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             pc_write;
    logic             branch;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             aluout_en;
    logic             mdr_en;
    logic             illegal_op;
    logic [3:0]       state;

    modport master (
        input  op, funct, zero, mem_ready,
        output ir_write, mem_read, mem_write, iord, pc_write, branch, pc_en,
               pc_src, alu_src_a, alu_src_b, alu_control, reg_write,
               mem_to_reg, reg_dst, aluout_en, mdr_en, illegal_op, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  ir_write, mem_read, mem_write, iord, pc_write, branch, pc_en,
               pc_src, alu_src_a, alu_src_b, alu_control, reg_write,
               mem_to_reg, reg_dst, aluout_en, mdr_en, illegal_op, state
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: R-type funct field to ALU control; unknown funct adds.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);
    // Map funct to ALU operation, falling back to add
    always_comb begin
        case (funct)
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM with multi-beat instruction fetch.
// The interface BEATS parameter must equal INSTR_W/BUS_W.
// Optional macro MC_CTRL_BNE_EN adds bne (op 000101) through the BRANCH state.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int BUS_W   = 8,
    parameter int INSTR_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);
    localparam int BEATS = INSTR_W / BUS_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [3:0]    state_q, state_n;
    logic [BW-1:0] beat_q, beat_n;
    logic          fetch_accept;
    logic          take;
    logic [2:0]    exec_alu;

    // A fetch beat completes only when memory answers; never while reset is held
    assign fetch_accept = (state_q == S_FETCH) && bus.mem_ready && !reset;

    mc_alu_decoder u_alu_dec (
        .funct       (bus.funct),
        .alu_control (exec_alu)
    );

`ifdef MC_CTRL_BNE_EN
    logic bne_q;

    // Remember whether the instruction being branched on is bne
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    bne_q <= 1'b0;
        else if (state_q == S_DECODE) bne_q <= (bus.op == OP_BNE);
    end

    assign take = bne_q ? ~bus.zero : bus.zero;
`else
    assign take = bus.zero;
`endif

    // State and beat registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
        end
    end

    // Next-state and beat counter sequencing
    always_comb begin
        state_n = S_FETCH;
        beat_n  = beat_q;
        case (state_q)
            S_FETCH: begin
                state_n = S_FETCH;
                if (fetch_accept) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = S_DECODE;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LB, OP_SB: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXEC;
                    OP_BEQ:       state_n = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_n = S_BRANCH;
`endif
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEMADR: state_n = (bus.op == OP_SB) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_n = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_n = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_n = S_ALUWB;
            default:  state_n = S_FETCH;
        endcase
    end

    // Moore control decode plus the mem_ready/zero gated outputs
    always_comb begin
        bus.ir_write    = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.pc_src      = PCSRC_ALU;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_REGB;
        bus.alu_control = ALU_ADD;
        bus.reg_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.aluout_en   = 1'b0;
        bus.mdr_en      = 1'b0;
        bus.illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_ONE;
                if (fetch_accept) begin
                    bus.ir_write = BEATS'(1) << beat_q;
                    bus.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_BOFF;
                bus.aluout_en = 1'b1;
                case (bus.op)
                    OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J: bus.illegal_op = 1'b0;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  bus.illegal_op = 1'b0;
`endif
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.aluout_en = 1'b1;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                bus.mdr_en   = bus.mem_ready;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_REGB;
                bus.aluout_en   = 1'b1;
                bus.alu_control = exec_alu;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_REGB;
                bus.alu_control = ALU_SUB;
                bus.branch      = 1'b1;
                bus.pc_src      = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.pc_en = bus.pc_write | (bus.branch & take);
    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven instruction runs with a scoreboard on the
// 8-bit-bus FSM, plus hand sequences for reset mid-write and a 16-bit bus.
module tb_mc_ctrl_fsm;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.BEATS(4)) if8 ();
    mc_ctrl_fsm_if #(.BEATS(2)) if16 ();

    mc_ctrl_fsm #(.BUS_W(8), .INSTR_W(32)) dut8 (
        .clock (clk),
        .reset (rst),
        .bus   (if8.master)
    );

    mc_ctrl_fsm #(.BUS_W(16), .INSTR_W(32)) dut16 (
        .clock (clk),
        .reset (rst),
        .bus   (if16.master)
    );

    // ---------------- expected-output record ----------------
    typedef struct packed {
        logic [3:0] state;
        logic [3:0] ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       branch;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       aluout_en;
        logic       mdr_en;
        logic       illegal_op;
    } out_t;

    localparam int W = $bits(out_t);

    // Instruction path classes
    localparam logic [2:0] P_LB  = 3'd0;
    localparam logic [2:0] P_SB  = 3'd1;
    localparam logic [2:0] P_R   = 3'd2;
    localparam logic [2:0] P_BR  = 3'd3;
    localparam logic [2:0] P_J   = 3'd4;
    localparam logic [2:0] P_ILL = 3'd5;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] fetch_stall;
        logic [3:0] mem_stall;
        logic [2:0] path;
        logic [2:0] exp_alu;
        logic       exp_pc_en;
    } vec_t;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests;
    int           n_fail;

    // Expected outputs for one cycle, written from the control table
    function automatic out_t model(input logic [3:0] st, input logic mr,
                                   input logic [3:0] ir, input logic pce,
                                   input logic [2:0] alu, input logic ill);
        out_t o;
        o = '0;
        o.state = st;
        o.alu_control = 3'b010;
        case (st)
            4'd0: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                o.ir_write = ir; o.pc_write = (ir != 4'd0); o.pc_en = (ir != 4'd0);
            end
            4'd1: begin o.alu_src_b = 2'b11; o.aluout_en = 1'b1; o.illegal_op = ill; end
            4'd2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.aluout_en = 1'b1; end
            4'd3: begin o.mem_read = 1'b1; o.iord = 1'b1; o.mdr_en = mr; end
            4'd4: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            4'd5: begin o.mem_write = 1'b1; o.iord = 1'b1; end
            4'd6: begin o.alu_src_a = 1'b1; o.aluout_en = 1'b1; o.alu_control = alu; end
            4'd7: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            4'd8: begin
                o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.branch = 1'b1;
                o.pc_src = 2'b01; o.pc_en = pce;
            end
            4'd9: begin o.pc_write = 1'b1; o.pc_src = 2'b10; o.pc_en = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct,
                                input logic zero, input logic [3:0] fs,
                                input logic [3:0] ms, input logic [2:0] path,
                                input logic [2:0] alu, input logic pce);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.fetch_stall = fs;
        v.mem_stall = ms; v.path = path; v.exp_alu = alu; v.exp_pc_en = pce;
        return v;
    endfunction

    // ---------------- scoreboard: compare at the falling edge ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  act;
            out_t  e;
            string nm;
            e  = out_t'(exp_q.pop_front());
            nm = name_q.pop_front();
            act.state = if8.state;         act.ir_write = if8.ir_write;
            act.mem_read = if8.mem_read;   act.mem_write = if8.mem_write;
            act.iord = if8.iord;           act.pc_write = if8.pc_write;
            act.branch = if8.branch;       act.pc_en = if8.pc_en;
            act.pc_src = if8.pc_src;       act.alu_src_a = if8.alu_src_a;
            act.alu_src_b = if8.alu_src_b; act.alu_control = if8.alu_control;
            act.reg_write = if8.reg_write; act.mem_to_reg = if8.mem_to_reg;
            act.reg_dst = if8.reg_dst;     act.aluout_en = if8.aluout_en;
            act.mdr_en = if8.mdr_en;       act.illegal_op = if8.illegal_op;
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got state=%0d outputs=%h, expected state=%0d outputs=%h",
                         nm, act.state, act, e.state, e);
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drive mem_ready, queue expectation, advance.
    task automatic cyc(input string nm, input logic [3:0] st, input logic mr,
                       input logic [3:0] ir, input logic pce,
                       input logic [2:0] alu, input logic ill);
        if8.mem_ready = mr;
        exp_q.push_back(W'(model(st, mr, ir, pce, alu, ill)));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_fetch(input int id, input int fetch_stall);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                for (int s = 0; s < fetch_stall; s++)
                    cyc($sformatf("v%0d_fetch_stall%0d", id, s), 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
            end
            cyc($sformatf("v%0d_fetch_beat%0d", id, k), 4'd0, 1'b1, 4'(1 << k), 1'b0, 3'd0, 1'b0);
        end
    endtask

    task automatic run_instr(input int id, input vec_t v);
        if8.op    = v.op;
        if8.funct = v.funct;
        if8.zero  = v.zero;
        run_fetch(id, int'(v.fetch_stall));
        cyc($sformatf("v%0d_decode", id), 4'd1, rnd_bit(), 4'd0, 1'b0, 3'd0, v.path == P_ILL);
        case (v.path)
            P_LB: begin
                cyc($sformatf("v%0d_memadr", id), 4'd2, rnd_bit(), 4'd0, 1'b0, 3'd0, 1'b0);
                for (int s = 0; s < int'(v.mem_stall); s++)
                    cyc($sformatf("v%0d_memrd_stall%0d", id, s), 4'd3, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
                cyc($sformatf("v%0d_memrd", id), 4'd3, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);
                cyc($sformatf("v%0d_memwb", id), 4'd4, rnd_bit(), 4'd0, 1'b0, 3'd0, 1'b0);
            end
            P_SB: begin
                cyc($sformatf("v%0d_memadr", id), 4'd2, rnd_bit(), 4'd0, 1'b0, 3'd0, 1'b0);
                for (int s = 0; s < int'(v.mem_stall); s++)
                    cyc($sformatf("v%0d_memwr_stall%0d", id, s), 4'd5, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
                cyc($sformatf("v%0d_memwr", id), 4'd5, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);
            end
            P_R: begin
                cyc($sformatf("v%0d_exec", id), 4'd6, rnd_bit(), 4'd0, 1'b0, v.exp_alu, 1'b0);
                cyc($sformatf("v%0d_aluwb", id), 4'd7, rnd_bit(), 4'd0, 1'b0, 3'd0, 1'b0);
            end
            P_BR: cyc($sformatf("v%0d_branch", id), 4'd8, rnd_bit(), 4'd0, v.exp_pc_en, 3'd0, 1'b0);
            P_J:  cyc($sformatf("v%0d_jump", id), 4'd9, rnd_bit(), 4'd0, 1'b0, 3'd0, 1'b0);
            default: ;
        endcase
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[17];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = mk(6'b000000, 6'b100000, 1'b0, 4'd0, 4'd0, P_R,   3'b010, 1'b0); // add
        vecs[1]  = mk(6'b000000, 6'b100010, 1'b0, 4'd0, 4'd0, P_R,   3'b110, 1'b0); // sub
        vecs[2]  = mk(6'b000000, 6'b100100, 1'b1, 4'd0, 4'd0, P_R,   3'b000, 1'b0); // and
        vecs[3]  = mk(6'b000000, 6'b100101, 1'b0, 4'd0, 4'd0, P_R,   3'b001, 1'b0); // or
        vecs[4]  = mk(6'b000000, 6'b101010, 1'b0, 4'd0, 4'd0, P_R,   3'b111, 1'b0); // slt
        vecs[5]  = mk(6'b000000, 6'b111111, 1'b0, 4'd0, 4'd0, P_R,   3'b010, 1'b0); // unknown funct
        vecs[6]  = mk(6'b100000, 6'b000000, 1'b0, 4'd0, 4'd0, P_LB,  3'b010, 1'b0); // lb
        vecs[7]  = mk(6'b100000, 6'b000000, 1'b0, 4'd0, 4'd3, P_LB,  3'b010, 1'b0); // lb, 3 stalls
        vecs[8]  = mk(6'b101000, 6'b000000, 1'b0, 4'd0, 4'd2, P_SB,  3'b010, 1'b0); // sb, 2 stalls
        vecs[9]  = mk(6'b000100, 6'b000000, 1'b1, 4'd0, 4'd0, P_BR,  3'b010, 1'b1); // beq taken
        vecs[10] = mk(6'b000100, 6'b000000, 1'b0, 4'd0, 4'd0, P_BR,  3'b010, 1'b0); // beq not taken
        vecs[11] = mk(6'b000010, 6'b000000, 1'b0, 4'd0, 4'd0, P_J,   3'b010, 1'b0); // j
        vecs[12] = mk(6'b111111, 6'b000000, 1'b0, 4'd0, 4'd0, P_ILL, 3'b010, 1'b0); // illegal
`ifdef MC_CTRL_BNE_EN
        vecs[13] = mk(6'b000101, 6'b000000, 1'b0, 4'd0, 4'd0, P_BR,  3'b010, 1'b1); // bne taken
        vecs[14] = mk(6'b000101, 6'b000000, 1'b1, 4'd0, 4'd0, P_BR,  3'b010, 1'b0); // bne not taken
`else
        vecs[13] = mk(6'b000101, 6'b000000, 1'b0, 4'd0, 4'd0, P_ILL, 3'b010, 1'b0); // bne illegal
        vecs[14] = mk(6'b000101, 6'b000000, 1'b1, 4'd0, 4'd0, P_ILL, 3'b010, 1'b0);
`endif
        vecs[15] = mk(6'b000000, 6'b100000, 1'b0, 4'd2, 4'd0, P_R,   3'b010, 1'b0); // fetch stall
        vecs[16] = mk(6'b000100, 6'b000000, 1'b1, 4'd1, 4'd0, P_BR,  3'b010, 1'b1);

        rst = 1'b1;
        if8.op = 6'd0;  if8.funct = 6'd0;  if8.zero = 1'b0;  if8.mem_ready = 1'b1;
        if16.op = 6'd0; if16.funct = 6'd0; if16.zero = 1'b0; if16.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with mem_ready=1: FETCH outputs but no IR/PC writes
        cyc("reset_hold", 4'd0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);
        check("reset16_state", 8'(if16.state), 8'd0);
        check("reset16_ir_write", 8'(if16.ir_write), 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_instr(i, vecs[i]);

        // Reset asserted while a store waits on memory
        if8.op = 6'b101000; if8.zero = 1'b0;
        run_fetch(100, 0);
        cyc("rw_decode", 4'd1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
        cyc("rw_memadr", 4'd2, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
        cyc("rw_memwr_wait", 4'd5, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
        #2;
        check("rw_mem_write_before", 8'(if8.mem_write), 8'd1);
        rst = 1'b1;
        #1;
        check("rw_mem_write_dropped", 8'(if8.mem_write), 8'd0);
        check("rw_state_fetch", 8'(if8.state), 8'd0);
        check("rw_mem_read", 8'(if8.mem_read), 8'd1);
        check("rw_ir_write", 8'(if8.ir_write), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First beat after reset must load slice 0
        run_instr(101, vecs[0]);

        // 16-bit bus: two beats, then decode a jump
        if16.op = 6'b000010;
        if16.mem_ready = 1'b1;
        @(negedge clk);
        check("b16_beat0_ir", 8'(if16.ir_write), 8'h01);
        check("b16_beat0_state", 8'(if16.state), 8'd0);
        @(negedge clk);
        check("b16_beat1_ir", 8'(if16.ir_write), 8'h02);
        @(negedge clk);
        check("b16_decode_state", 8'(if16.state), 8'd1);
        check("b16_decode_ir", 8'(if16.ir_write), 8'h00);
        @(negedge clk);
        check("b16_jump_state", 8'(if16.state), 8'd9);
        check("b16_jump_pc_en", 8'(if16.pc_en), 8'd1);
        @(negedge clk);
        check("b16_refetch_state", 8'(if16.state), 8'd0);
        check("b16_refetch_ir", 8'(if16.ir_write), 8'h01);
        if16.mem_ready = 1'b0;

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle MIPS control FSM; next generation of the byte-fetch control unit.
- Fetches an INSTR_W instruction over a BUS_W memory bus in INSTR_W/BUS_W beats.
- Waits on a memory-ready handshake and sequences lb/sb/R-type/beq/j.
- Sits between instruction register/datapath and unified memory; all datapath mux/enable controls originate here.

Parameters:
- BUS_W, 8, memory data bus width in bits; must divide INSTR_W.
- INSTR_W, 32, instruction width in bits.
- BEATS, INSTR_W/BUS_W (derived localparam), fetch beats per instruction; ir_write width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- op  in  6  opcode from IR
- funct  in  6  function field from IR
- zero  in  1  ALU zero flag, combinational from current ALU result
- mem_ready  in  1  memory completed current access this cycle
- ir_write  out  BEATS  one-hot IR slice enable; beat k loads slice k (LSB first)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  0=PC address, 1=ALUOut address
- pc_write  out  1  unconditional PC load
- branch  out  1  branch state active
- pc_en  out  1  pc_write | (branch & take), take=zero for beq
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 1, 10=sign-ext imm, 11=imm branch offset
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_write, mem_to_reg, reg_dst  out  1 each  register-file write controls
- aluout_en, mdr_en  out  1 each  ALUOut / memory-data register enables
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state encoding (debug)

Behaviour:
- Moore outputs decoded combinationally from state register plus beat counter; only exception is pc_en/ir_write/pc_write gating by mem_ready and zero as stated.
- Reset (async): state=FETCH, beat=0. Outputs while reset held: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, ir_write=0, pc_write=0, all others 0.
- Default for every output not named in a state: 0; alu_control defaults to 010.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010.
  - If mem_ready=1: ir_write=1<<beat, pc_write=1, beat increments.
  - If mem_ready=0: hold; no ir_write, no pc_write.
  - On accepted beat BEATS-1, beat wraps to 0 and next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, aluout_en=1 (branch target). Next state by op:
  - 100000/101000 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - otherwise illegal_op=1 and next state FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, aluout_en=1. lb -> MEMRD; sb -> MEMWR.
- MEMRD: mem_read=1, iord=1, mdr_en=mem_ready. Leaves to MEMWB only when mem_ready=1.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
- MEMWR: mem_write=1, iord=1. Held until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, aluout_en=1, alu_control from funct.
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct gives add; not flagged.
  - Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, branch=1, pc_src=01, aluout_en=0 (preserves target), pc_en=zero; next state FETCH.
- JUMP: pc_write=1, pc_src=10; next state FETCH.
- Unused encodings -> FETCH next cycle; illegal_op stays 0.
- Reset mid-operation: immediate return to FETCH, beat=0; pending mem_write drops asynchronously.
- mem_ready is ignored in states that make no memory request.
- Latency with no stalls, in cycles:
  - lb = BEATS+4
  - sb = BEATS+3
  - R-type = BEATS+3
  - beq and j = BEATS+2
  - Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) decodes to BRANCH with identical outputs except pc_en=branch & ~zero; op is held in a 1-bit registered flag captured in DECODE.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum/localparams: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9
  - opcode and funct constants
  - alu_control codes
  - pc_src and alu_src_b encodings
- One sub-module: mc_alu_decoder, combinational funct -> alu_control with add default; instantiated for EXEC.

Test Plan:
- BUS_W=8, mem_ready=1, add instruction -> ir_write 0001,0010,0100,1000 on cycles 0-3; DECODE cycle 4; EXEC alu_control=010; ALUWB reg_write=1, reg_dst=1; FETCH cycle 7.
- Fetch with mem_ready low cycles 1-2 -> ir_write/pc_write 0 while stalled; beat 1 accepted cycle 3; DECODE at cycle 6.
- lb with MEMRD mem_ready low 3 cycles -> mem_read=1, iord=1 held 4 cycles; MEMWB mem_to_reg=1; total 11 cycles.
- beq zero=1 then zero=0 -> pc_en 1 then 0 in BRANCH, pc_src=01, aluout_en=0; sb -> mem_write held until mem_ready.
- op=111111 -> illegal_op high exactly one cycle in DECODE; next state FETCH. With MC_CTRL_BNE_EN, op=000101, zero=0 -> pc_en=1.
- BUS_W=16 (BEATS=2) -> ir_write 01,10 then DECODE. Reset asserted mid-MEMWR -> mem_write=0 immediately; state=FETCH, beat=0.
